// File: rtl/clip_record_play_ctrl.sv
// rtl/clip_record_play_ctrl.sv - multi-clip audio record/playback sequencer over a shared sample RAM
module clip_record_play_ctrl #(
    parameter int NUM_CLIPS = 4,
    parameter int CLIP_AW   = 15,
    parameter int SEL_W     = $clog2(NUM_CLIPS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     play_req,
    input  logic                     record_req,
    input  logic                     stop_req,
    input  logic [SEL_W-1:0]         clip_sel,
    input  logic                     sample_tick,
    output logic                     mem_en,
    output logic                     mem_wen,
    output logic [SEL_W+CLIP_AW-1:0] mem_addr,
    output logic                     des_en,
    output logic                     ser_en,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [NUM_CLIPS-1:0]     clip_valid
);

    // One extra offset bit so a full-length clip count (2**CLIP_AW) is representable.
    localparam int OFF_W = CLIP_AW + 1;
    localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_LAST = {1'b0, {CLIP_AW{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [OFF_W-1:0]     offset_q, offset_d;
    logic [OFF_W-1:0]     len_q [NUM_CLIPS];
    logic [OFF_W-1:0]     len_d [NUM_CLIPS];
    logic [NUM_CLIPS-1:0] valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    // Next-state logic: request arbitration in IDLE, stop-before-tick in active states.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        offset_d = offset_q;
        len_d    = len_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (play_req) begin
                    if (valid_q[clip_sel]) begin
                        sel_d    = clip_sel;
                        offset_d = '0;
                        state_d  = S_PLAY;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (record_req) begin
                    sel_d            = clip_sel;
                    offset_d         = '0;
                    valid_d[clip_sel] = 1'b0;
                    state_d          = S_RECORD;
                end
            end
            S_RECORD: begin
                if (stop_req) begin
                    len_d[sel_q]   = offset_q;
                    valid_d[sel_q] = (offset_q != '0);
                    done_d         = 1'b1;
                    state_d        = S_IDLE;
                end else if (sample_tick) begin
                    offset_d = offset_q + OFF_ONE;
                    if (offset_q == OFF_LAST) begin
                        len_d[sel_q]   = offset_q + OFF_ONE;
                        valid_d[sel_q] = 1'b1;
                        done_d         = 1'b1;
                        state_d        = S_IDLE;
                    end
                end
            end
            S_PLAY: begin
                if (stop_req) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (sample_tick) begin
                    offset_d = offset_q + OFF_ONE;
                    if (offset_q == len_q[sel_q] - OFF_ONE) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset discards any partial recording.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            offset_q <= '0;
            valid_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_CLIPS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            offset_q <= offset_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            for (int i = 0; i < NUM_CLIPS; i++) begin
                len_q[i] <= len_d[i];
            end
        end
    end

    // Output decode; a tick that coincides with stop never reaches the RAM.
    always_comb begin
        busy       = (state_q != S_IDLE);
        des_en     = (state_q == S_RECORD);
        ser_en     = (state_q == S_PLAY);
        mem_en     = busy && sample_tick && !stop_req;
        mem_wen    = des_en && sample_tick && !stop_req;
        mem_addr   = busy ? {sel_q, offset_q[CLIP_AW-1:0]} : '0;
        done       = done_q;
        err        = err_q;
        clip_valid = valid_q;
    end

endmodule

// File: tb/tb_clip_record_play_ctrl.sv
// tb/tb_clip_record_play_ctrl.sv - directed self-checking bench for clip_record_play_ctrl
module tb_clip_record_play_ctrl;

    localparam int NUM_CLIPS = 4;
    localparam int CLIP_AW   = 4;
    localparam int SEL_W     = 2;
    localparam int AW        = SEL_W + CLIP_AW;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 play_req, record_req, stop_req, sample_tick;
    logic [SEL_W-1:0]     clip_sel;
    logic                 mem_en, mem_wen, des_en, ser_en, busy, done, err;
    logic [AW-1:0]        mem_addr;
    logic [NUM_CLIPS-1:0] clip_valid;

    int n_assert = 0;
    int n_fail   = 0;

    clip_record_play_ctrl #(
        .NUM_CLIPS (NUM_CLIPS),
        .CLIP_AW   (CLIP_AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .play_req    (play_req),
        .record_req  (record_req),
        .stop_req    (stop_req),
        .clip_sel    (clip_sel),
        .sample_tick (sample_tick),
        .mem_en      (mem_en),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .des_en      (des_en),
        .ser_en      (ser_en),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .clip_valid  (clip_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_ticks(input int n, input int sel, input logic wen, input string tag);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(negedge clock);
            chk({tag, "_mem_en"}, 32'(mem_en), 32'd1);
            chk({tag, "_mem_wen"}, 32'(mem_wen), 32'(wen));
            chk({tag, "_addr"}, 32'(mem_addr), 32'(sel * 16 + i));
            chk({tag, "_done_mid"}, 32'(done), 32'd0);
            step();
            sample_tick = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; play_req = 1'b0; record_req = 1'b0; stop_req = 1'b0;
        sample_tick = 1'b0; clip_sel = '0;
        step(); step();
        @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(clip_valid), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_enables", 32'({des_en, ser_en, mem_en, err}), 32'd0);
        step();
        reset = 1'b0;

        // 1: record clip 2 for 10 ticks then stop (stop tick not written)
        clip_sel = 2'd2; record_req = 1'b1;
        @(negedge clock);
        chk("t1_busy_pre", 32'(busy), 32'd0);
        step();
        record_req = 1'b0;
        @(negedge clock);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_des_en", 32'(des_en), 32'd1);
        step();
        run_ticks(10, 2, 1'b1, "t1");
        stop_req = 1'b1; sample_tick = 1'b1;
        @(negedge clock);
        chk("t1_stop_tick_mem_en", 32'(mem_en), 32'd0);
        step();
        stop_req = 1'b0; sample_tick = 1'b0;
        @(negedge clock);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_post", 32'(busy), 32'd0);
        chk("t1_des_en_post", 32'(des_en), 32'd0);
        chk("t1_valid", 32'(clip_valid), 32'h4);
        step();
        @(negedge clock);
        chk("t1_done_pulse", 32'(done), 32'd0);
        step();

        // 2: play clip 2, 10 reads, ends by itself
        clip_sel = 2'd2; play_req = 1'b1;
        step();
        play_req = 1'b0;
        @(negedge clock);
        chk("t2_ser_en", 32'(ser_en), 32'd1);
        step();
        run_ticks(10, 2, 1'b0, "t2");
        @(negedge clock);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_ser_en_post", 32'(ser_en), 32'd0);
        chk("t2_busy_post", 32'(busy), 32'd0);
        step();

        // 3: play an empty clip is rejected
        clip_sel = 2'd1; play_req = 1'b1;
        step();
        play_req = 1'b0; sample_tick = 1'b1;
        @(negedge clock);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_mem_en", 32'(mem_en), 32'd0);
        step();
        sample_tick = 1'b0;
        @(negedge clock);
        chk("t3_err_pulse", 32'(err), 32'd0);
        step();

        // 4: play wins over record; then stop in IDLE does nothing
        clip_sel = 2'd2; play_req = 1'b1; record_req = 1'b1;
        step();
        play_req = 1'b0; record_req = 1'b0;
        @(negedge clock);
        chk("t4_ser_en", 32'(ser_en), 32'd1);
        chk("t4_des_en", 32'(des_en), 32'd0);
        step();
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        @(negedge clock);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_valid", 32'(clip_valid), 32'h4);
        step();
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        @(negedge clock);
        chk("t4_idle_stop_done", 32'(done), 32'd0);
        chk("t4_idle_stop_busy", 32'(busy), 32'd0);
        step();

        // 5: full-length record of clip 0, then play back all 16 samples
        clip_sel = 2'd0; record_req = 1'b1;
        step();
        record_req = 1'b0;
        run_ticks(16, 0, 1'b1, "t5r");
        @(negedge clock);
        chk("t5_rec_done", 32'(done), 32'd1);
        chk("t5_rec_busy", 32'(busy), 32'd0);
        chk("t5_valid", 32'(clip_valid), 32'h5);
        step();
        clip_sel = 2'd0; play_req = 1'b1;
        step();
        play_req = 1'b0;
        run_ticks(16, 0, 1'b0, "t5p");
        @(negedge clock);
        chk("t5_play_done", 32'(done), 32'd1);
        chk("t5_play_busy", 32'(busy), 32'd0);
        step();

        // 6: reset mid-record of clip 2 aborts with no done
        clip_sel = 2'd2; record_req = 1'b1;
        step();
        record_req = 1'b0;
        @(negedge clock);
        chk("t6_valid_cleared", 32'(clip_valid), 32'h1);
        step();
        run_ticks(5, 2, 1'b1, "t6");
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_des_en", 32'(des_en), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_valid", 32'(clip_valid), 32'h0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        step();
        @(negedge clock);
        chk("t6_done_later", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
